// File: rtl/point_delta_prep.sv
// Point-pair delta preprocessor for the CORDIC vectoring core: saturated dx/dy,
// right-half-plane fold, sequence tagging, and a skid FIFO behind valid/ready.
module point_delta_prep #(
    parameter int W     = 16,
    parameter int SEQ_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in1,
    input  logic signed [W-1:0] y_in1,
    input  logic signed [W-1:0] x_in2,
    input  logic signed [W-1:0] y_in2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] dx_out,
    output logic signed [W-1:0] dy_out,
    output logic                neg_flag,
    output logic                sat_flag,
    output logic [SEQ_W-1:0]    seq_out
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam int E_W = 2*W + 2 + SEQ_W;

    // Returns {sat, b - a} with the W+1 bit difference clamped into W bits.
    function automatic logic [W:0] sat_sub(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        logic [W:0] d;
        d = {b[W-1], b} - {a[W-1], a};
        if (d[W] != d[W-1]) begin
            return {1'b1, (d[W] ? MIN_V : MAX_V)};
        end
        return {1'b0, d[W-1:0]};
    endfunction

    // Returns {sat, -a}; the most negative value has no positive twin.
    function automatic logic [W:0] sat_neg(input logic signed [W-1:0] a);
        if (a == MIN_V) begin
            return {1'b1, MAX_V};
        end
        return {1'b0, -a};
    endfunction

    logic                accept;
    logic                pop;
    logic                advance;
    logic [1:0]          occ;

    logic [W:0]          sub_x;
    logic [W:0]          sub_y;

    logic                s1_vld_q, s1_vld_d;
    logic signed [W-1:0] s1_dx_q;
    logic signed [W-1:0] s1_dy_q;
    logic                s1_sat_q;
    logic [SEQ_W-1:0]    s1_seq_q;
    logic [SEQ_W-1:0]    seq_q, seq_d;

    logic [W:0]          neg_x;
    logic [W:0]          neg_y;
    logic signed [W-1:0] fold_dx;
    logic signed [W-1:0] fold_dy;
    logic                fold_neg;
    logic                fold_sat;
    logic [E_W-1:0]      push_entry;

    logic [E_W-1:0]      mem_q [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [E_W-1:0]      head;

    assign occ       = cnt_q + {1'b0, s1_vld_q};
    assign in_ready  = (occ != 2'd3);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign advance   = s1_vld_q && ((cnt_q != 2'd2) || pop);

    assign sub_x = sat_sub(x_in1, x_in2);
    assign sub_y = sat_sub(y_in1, y_in2);

    // ---- input -> S1 ----
    always_comb begin
        s1_vld_d = s1_vld_q;
        if (accept) begin
            s1_vld_d = 1'b1;
        end else if (advance) begin
            s1_vld_d = 1'b0;
        end
        seq_d = accept ? seq_q + 1'b1 : seq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            seq_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            seq_q    <= seq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_dx_q  <= sub_x[W-1:0];
            s1_dy_q  <= sub_y[W-1:0];
            s1_sat_q <= sub_x[W] | sub_y[W];
            s1_seq_q <= seq_q;
        end
    end

    // ---- S1 -> fold -> FIFO ----
    always_comb begin
        neg_x    = sat_neg(s1_dx_q);
        neg_y    = sat_neg(s1_dy_q);
        fold_neg = s1_dx_q[W-1];
        fold_dx  = s1_dx_q;
        fold_dy  = s1_dy_q;
        fold_sat = s1_sat_q;
        if (fold_neg) begin
            fold_dx  = neg_x[W-1:0];
            fold_dy  = neg_y[W-1:0];
            fold_sat = s1_sat_q | neg_x[W] | neg_y[W];
        end
        push_entry = {fold_dx, fold_dy, fold_neg, fold_sat, s1_seq_q};
    end

    always_comb begin
        wr_ptr_d = advance ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        cnt_d    = cnt_q;
        if (advance && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !advance) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ---- FIFO head -> outputs ----
    // Data storage is never reset, so the outputs are forced to zero while empty.
    assign head     = mem_q[rd_ptr_q];
    assign dx_out   = out_valid ? head[E_W-1 -: W]          : '0;
    assign dy_out   = out_valid ? head[E_W-W-1 -: W]        : '0;
    assign neg_flag = out_valid ? head[SEQ_W+1]             : 1'b0;
    assign sat_flag = out_valid ? head[SEQ_W]               : 1'b0;
    assign seq_out  = out_valid ? head[SEQ_W-1:0]           : '0;

endmodule

// File: tb/tb_point_delta_prep.sv
// Randomized and directed bench for point_delta_prep against an in-order
// arithmetic reference of the accepted pairs.
module tb_point_delta_prep;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in1, y_in1, x_in2, y_in2;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dx_out, dy_out;
    logic               neg_flag, sat_flag;
    logic [7:0]         seq_out;

    point_delta_prep #(.W(16), .SEQ_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in1(x_in1), .y_in1(y_in1), .x_in2(x_in2), .y_in2(y_in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .dx_out(dx_out), .dy_out(dy_out),
        .neg_flag(neg_flag), .sat_flag(sat_flag), .seq_out(seq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] dx;
        logic signed [15:0] dy;
        bit                 neg;
        bit                 sat;
        logic [7:0]         seq;
        int                 acc;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    bit         ev;
    logic [7:0] mseq = 8'd0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_pops = 0;
    bit         chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // The pair's result from plain integer arithmetic.
    function automatic exp_t ref_calc(input logic signed [15:0] a1, input logic signed [15:0] b1,
                                      input logic signed [15:0] a2, input logic signed [15:0] b2);
        exp_t r;
        int dx, dy;
        r.neg = 0; r.sat = 0; r.seq = 0; r.acc = 0;
        dx = int'(a2) - int'(a1);
        dy = int'(b2) - int'(b1);
        if (dx > 32767) begin dx = 32767; r.sat = 1; end
        if (dx < -32768) begin dx = -32768; r.sat = 1; end
        if (dy > 32767) begin dy = 32767; r.sat = 1; end
        if (dy < -32768) begin dy = -32768; r.sat = 1; end
        if (dx < 0) begin
            r.neg = 1;
            dx = -dx;
            dy = -dy;
            if (dx > 32767) begin dx = 32767; r.sat = 1; end
            if (dy > 32767) begin dy = 32767; r.sat = 1; end
        end
        r.dx = dx[15:0];
        r.dy = dy[15:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            ev = (q.size() > 0) && (cyc >= q[0].acc + 1);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, q.size() < 3);
            if (out_valid && out_ready && q.size() > 0) begin
                chk("dx_out", dx_out, q[0].dx);
                chk("dy_out", dy_out, q[0].dy);
                chk("neg_flag", neg_flag, q[0].neg);
                chk("sat_flag", sat_flag, q[0].sat);
                chk("seq_out", seq_out, q[0].seq);
            end
            if (rst) begin
                q.delete();
                mseq = 8'd0;
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() > 0) e = q.pop_front();
                    n_pops++;
                end
                if (in_valid && in_ready) begin
                    e = ref_calc(x_in1, y_in1, x_in2, y_in2);
                    e.seq = mseq;
                    e.acc = cyc + 1;
                    q.push_back(e);
                    mseq = mseq + 8'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [15:0] a1, input logic signed [15:0] b1,
                         input logic signed [15:0] a2, input logic signed [15:0] b2);
        x_in1 = a1; y_in1 = b1; x_in2 = a2; y_in2 = b2;
    endtask

    task automatic send(input logic signed [15:0] a1, input logic signed [15:0] b1,
                        input logic signed [15:0] a2, input logic signed [15:0] b2);
        bit got;
        got = 0;
        drive(a1, b1, a2, b2);
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string name, input logic signed [15:0] dx, input logic signed [15:0] dy,
                              input bit neg, input bit sat, input logic [7:0] seq);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_dx"}, dx_out, dx);
        chk({name, "_dy"}, dy_out, dy);
        chk({name, "_neg"}, neg_flag, neg);
        chk({name, "_sat"}, sat_flag, sat);
        chk({name, "_seq"}, seq_out, seq);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic signed [15:0] rnd16();
        case ($urandom % 6)
            0: return 16'sh8000;
            1: return 16'sh7fff;
            2: return 16'sh0000;
            3: return 16'($signed($urandom_range(0, 64)) - 32);
            default: return 16'($urandom);
        endcase
    endfunction

    int k, p0, stalls;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_dx", dx_out, 16'd0);
        chk("rst_dy", dy_out, 16'd0);
        chk("rst_flags", {neg_flag, sat_flag}, 2'b00);
        chk("rst_seq", seq_out, 8'd0);
        tick();
        rst = 1'b0;

        send(0, 0, 400, 300);
        expect_out("t1", 400, 300, 0, 0, 0);
        send(1000, 500, 800, 200);
        expect_out("t2", 200, 300, 1, 0, 1);
        send(-32768, 0, 32767, -32768);
        expect_out("t3a", 32767, -32768, 0, 1, 2);
        send(0, 0, -32768, 5);
        expect_out("t3b", 32767, -5, 1, 1, 3);

        // Backpressure: three pairs fit, then the block stalls.
        do_reset();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 5);
            drive(16'(k * 10), 16'(k), 16'(k * 10 + 7 + k), 16'(-k));
            @(negedge clk);
            if (in_valid && in_ready) k++;
            tick();
        end
        chk("t4_accepted_blocked", k, 3);
        @(negedge clk);
        chk("t4_in_ready_blocked", in_ready, 1'b0);
        tick();
        p0 = n_pops;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && k < 5; c++) begin
            in_valid = 1'b1;
            drive(16'(k * 10), 16'(k), 16'(k * 10 + 7 + k), 16'(-k));
            @(negedge clk);
            if (in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t4_accepted_all", k, 5);
        chk("t4_pops", n_pops - p0, 5);

        // Sustained stream, sequence wraps past 255.
        do_reset();
        out_ready = 1'b1;
        p0 = n_pops;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            drive(rnd16(), rnd16(), rnd16(), rnd16());
            @(negedge clk);
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5_stalls", stalls, 0);
        chk("t5_pops", n_pops - p0, 300);

        // Reset with three pairs in flight.
        do_reset();
        out_ready = 1'b0;
        send(1, 1, 2, 2);
        send(3, 3, 1, 1);
        send(5, 5, 9, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b1;
        send(1, 2, 3, 4);
        expect_out("t6_after", 2, 2, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 6;
            rst       = ($urandom % 300) == 0;
            drive(rnd16(), rnd16(), rnd16(), rnd16());
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("drain_out_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
